kuz_round_sched: RTL and testbench

Round scheduler for the GOST R 34.12-2015 (Kuznyechik) block core. It sits between the round-key store, with its key-expansion FSM, and the single-round LSX datapath. It gates block processing on key availability and serialises key reloads against in-flight blocks. For each accepted block it drives the key-store read address and the round strobes for 10 steps.

---
 rtl/kuz_pkg.sv | 17 +
 rtl/kuz_key_ptr.sv | 36 +++
 rtl/kuz_round_sched.sv | 119 +++++++++++
 tb/tb_kuz_round_sched.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/kuz_pkg.sv
// Shared constants and scheduler state encoding for the Kuznyechik block core.
package kuz_pkg;

  localparam int KUZ_ROUNDS  = 10;
  localparam int KUZ_KADDR_W = 5;

  localparam logic [KUZ_KADDR_W-1:0] KUZ_ADDR_LAST = KUZ_KADDR_W'(KUZ_ROUNDS - 1);

  typedef enum logic [2:0] {
    NOKEY,
    RELOAD,
    IDLE,
    RUN,
    DONE
  } kuz_sched_state_t;

endpackage

// File: rtl/kuz_key_ptr.sv
// Round-key address counter: counts 0..9 while a block runs, saturates, and maps
// to descending addresses for decryption when KUZ_DECRYPT_EN is defined.
module kuz_key_ptr
  import kuz_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   run,
  input  logic                   run_next,
  input  logic                   dir,
  output logic [KUZ_KADDR_W-1:0] key_addr
);

  logic [KUZ_KADDR_W-1:0] acnt_q;

  // NOTE: state registers use non-blocking assignments and an asynchronous active-low
  // reset so every flop updates from pre-edge values and clears without a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acnt_q <= '0;
    end else if (!run_next) begin
      acnt_q <= '0;
    end else if (run && (acnt_q != KUZ_ADDR_LAST)) begin
      acnt_q <= acnt_q + KUZ_KADDR_W'(1);
    end
  end

`ifdef KUZ_DECRYPT_EN
  assign key_addr = dir ? (KUZ_ADDR_LAST - acnt_q) : acnt_q;
`else
  logic unused_dir;
  assign unused_dir = dir;
  assign key_addr   = acnt_q;
`endif

endmodule

// File: rtl/kuz_round_sched.sv
// Kuznyechik round scheduler: gates blocks on key availability, serialises key reloads
// and sequences 10 round steps. Optional macro KUZ_DECRYPT_EN enables decryption.
module kuz_round_sched
  import kuz_pkg::*;
#(
  parameter int KEY_LAT = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   key_req,
  output logic                   key_start,
  input  logic                   key_ready_s,
  output logic                   key_valid,
  output logic [KUZ_KADDR_W-1:0] key_addr,
  input  logic                   blk_valid,
  input  logic                   blk_dec,
  output logic                   blk_ready,
  output logic                   blk_load,
  output logic                   round_en,
  output logic [3:0]             round_idx,
  output logic                   xor_only,
  output logic                   round_dir,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam logic [4:0] CYC_FIRST = 5'(KEY_LAT);
  localparam logic [4:0] CYC_LAST  = 5'(KEY_LAT + KUZ_ROUNDS - 1);

  kuz_sched_state_t state_q, state_d;
  logic             pend_q;
  logic             key_valid_q;
  logic             key_start_q;
  logic [4:0]       cyc_q;
  logic             dir_q;
  logic             accept;
  logic             reload_entry;

  assign blk_ready = (state_q == IDLE) && !pend_q;
  assign accept    = blk_valid && blk_ready;

  // NOTE: every combinational output gets a default before the case so no path
  // through the block leaves a value unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      NOKEY:   if (key_req) state_d = RELOAD;
      RELOAD:  if (key_req) state_d = RELOAD;
               else if (key_ready_s) state_d = IDLE;
      IDLE:    if (accept) state_d = RUN;
               else if (key_req || pend_q) state_d = RELOAD;
      RUN:     if (cyc_q == CYC_LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = (pend_q || key_req) ? RELOAD : IDLE;
      default: state_d = NOKEY;
    endcase
  end

  // A key_req while already reloading restarts the expansion, so it counts as a new entry.
  assign reload_entry = (state_d == RELOAD) && ((state_q != RELOAD) || key_req);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= NOKEY;
      pend_q      <= 1'b0;
      key_valid_q <= 1'b0;
      key_start_q <= 1'b0;
      cyc_q       <= '0;
    end else begin
      state_q     <= state_d;
      key_start_q <= reload_entry;
      if (reload_entry) begin
        key_valid_q <= 1'b0;
      end else if ((state_q == RELOAD) && (state_d == IDLE)) begin
        key_valid_q <= 1'b1;
      end
      if (reload_entry) begin
        pend_q <= 1'b0;
      end else if (key_req && ((state_q == RUN) || (state_q == DONE) || accept)) begin
        pend_q <= 1'b1;
      end
      cyc_q <= ((state_q == RUN) && (state_d == RUN)) ? cyc_q + 5'd1 : 5'd0;
    end
  end

`ifdef KUZ_DECRYPT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_q <= 1'b0;
    end else if (accept) begin
      dir_q <= blk_dec;
    end
  end
`else
  logic unused_blk_dec;
  assign unused_blk_dec = blk_dec;
  assign dir_q          = 1'b0;
`endif

  kuz_key_ptr u_key_ptr (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (state_q == RUN),
    .run_next (state_d == RUN),
    .dir      (dir_q),
    .key_addr (key_addr)
  );

  // Steps trail the address counter by the key-store read latency.
  assign round_en  = (state_q == RUN) && (cyc_q >= CYC_FIRST);
  assign round_idx = round_en ? 4'(cyc_q - CYC_FIRST) : 4'd0;
  assign xor_only  = round_en && (round_idx == 4'(KUZ_ROUNDS - 1));

  assign key_start = key_start_q;
  assign key_valid = key_valid_q;
  assign blk_load  = accept;
  assign round_dir = dir_q;
  assign out_valid = (state_q == DONE);

endmodule

// File: tb/tb_kuz_round_sched.sv
// Self-checking bench for kuz_round_sched; expected key addresses and steps are queued
// at block acceptance and popped as the scheduler produces them.
module tb_kuz_round_sched;

  localparam int KL = 2;
`ifdef KUZ_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       key_req, key_ready_s, blk_valid, blk_dec, out_ready;
  logic       key_start, key_valid, blk_ready, blk_load, round_en, xor_only, round_dir, out_valid;
  logic [4:0] key_addr;
  logic [3:0] round_idx;

  int n_cmp = 0;
  int n_bad = 0;

  logic [4:0] addr_q[$];
  logic [4:0] step_q[$];   // {xor_only, round_idx}

  wire [16:0] outs_all = {key_start, key_valid, key_addr, blk_ready, blk_load,
                          round_en, round_idx, xor_only, round_dir, out_valid};

  always #5 clk = ~clk;

  kuz_round_sched #(.KEY_LAT(KL)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .key_req     (key_req),
    .key_start   (key_start),
    .key_ready_s (key_ready_s),
    .key_valid   (key_valid),
    .key_addr    (key_addr),
    .blk_valid   (blk_valid),
    .blk_dec     (blk_dec),
    .blk_ready   (blk_ready),
    .blk_load    (blk_load),
    .round_en    (round_en),
    .round_idx   (round_idx),
    .xor_only    (xor_only),
    .round_dir   (round_dir),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  // Full reload: key_req pulse, key_ready_s after gap cycles; exactly one key_start.
  task automatic do_reload(input int gap);
    int starts;
    key_req = 1'b1;
    @(negedge clk); key_req = 1'b0; #1;
    n_cmp++; if (key_start !== 1'b1) begin n_bad++; $display("FAIL reload_start: key_start=%b want 1", key_start); end
    n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL reload_kv_low: key_valid=%b want 0", key_valid); end
    starts = 0;
    for (int i = 1; i < gap; i++) begin
      @(negedge clk); #1;
      if (key_start === 1'b1) starts++;
    end
    n_cmp++; if (starts != 0) begin n_bad++; $display("FAIL reload_one_pulse: extra key_start=%0d want 0", starts); end
    n_cmp++; if (blk_ready !== 1'b0) begin n_bad++; $display("FAIL reload_blk_ready: blk_ready=%b want 0", blk_ready); end
    key_ready_s = 1'b1;
    @(negedge clk); key_ready_s = 1'b0; #1;
    n_cmp++; if (key_valid !== 1'b1) begin n_bad++; $display("FAIL reload_kv: key_valid=%b want 1", key_valid); end
    n_cmp++; if (blk_ready !== 1'b1) begin n_bad++; $display("FAIL reload_ready: blk_ready=%b want 1", blk_ready); end
  endtask

  // Drive one block; key_req pulsed at cycle kreq_at (0 = acceptance cycle, -1 = never),
  // out_ready withheld for hold cycles after out_valid. Returns just after the handshake.
  task automatic run_block(input logic dec, input int kreq_at, input int hold, output int waited);
    logic [4:0] ea, es;
    logic       exp_en;
    logic       exp_dir;
    waited = 0;
    while (blk_ready !== 1'b1 && waited < 60) begin
      @(negedge clk); #1; waited++;
    end
    n_cmp++; if (blk_ready !== 1'b1) begin n_bad++; $display("FAIL blk_ready_timeout: blk_ready=%b want 1", blk_ready); end
    exp_dir   = DEC_EN & dec;
    blk_valid = 1'b1; blk_dec = dec; key_req = (kreq_at == 0);
    #1;
    n_cmp++; if (blk_load !== 1'b1) begin n_bad++; $display("FAIL blk_load: blk_load=%b want 1", blk_load); end
    for (int k = 0; k < 10; k++) begin
      addr_q.push_back(exp_dir ? 5'(9 - k) : 5'(k));
      step_q.push_back({k == 9, 4'(k)});
    end
    for (int c = 1; c <= 11 + KL; c++) begin
      @(negedge clk); blk_valid = 1'b0; key_req = (kreq_at == c); #1;
      if (c <= 10) begin
        ea = addr_q.pop_front();
        n_cmp++; if (key_addr !== ea) begin n_bad++; $display("FAIL key_addr c=%0d: got %0d want %0d", c, key_addr, ea); end
      end
      exp_en = (c >= 1 + KL) && (c <= 10 + KL);
      n_cmp++; if (round_en !== exp_en) begin n_bad++; $display("FAIL round_en c=%0d: got %b want %b", c, round_en, exp_en); end
      if (exp_en) begin
        es = step_q.pop_front();
        n_cmp++; if ({xor_only, round_idx} !== es) begin n_bad++; $display("FAIL step c=%0d: got xor=%b idx=%0d want xor=%b idx=%0d", c, xor_only, round_idx, es[4], es[3:0]); end
      end else begin
        n_cmp++; if (xor_only !== 1'b0) begin n_bad++; $display("FAIL xor_idle c=%0d: got %b want 0", c, xor_only); end
      end
      n_cmp++; if (out_valid !== (c == 11 + KL)) begin n_bad++; $display("FAIL out_valid c=%0d: got %b want %b", c, out_valid, c == 11 + KL); end
      n_cmp++; if ({blk_ready, round_dir} !== {1'b0, exp_dir}) begin n_bad++; $display("FAIL ready_dir c=%0d: got %b%b want 0%b", c, blk_ready, round_dir, exp_dir); end
    end
    key_req = 1'b0;
    n_cmp++; if ((addr_q.size() + step_q.size()) != 0) begin n_bad++; $display("FAIL queue_left: got %0d want 0", addr_q.size() + step_q.size()); end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      n_cmp++; if ({out_valid, blk_ready, key_start} !== 3'b100) begin n_bad++; $display("FAIL hold h=%0d: got ov/rdy/ks=%b want 100", h, {out_valid, blk_ready, key_start}); end
    end
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; key_req = 1'b0; key_ready_s = 1'b0;
    blk_valid = 1'b0; blk_dec = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (outs_all !== 17'd0) begin n_bad++; $display("FAIL reset_outs: got %h want 0", outs_all); end
    reset_n = 1'b1;
    blk_valid = 1'b1; key_ready_s = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); key_ready_s = 1'b0; #1;
      n_cmp++; if ({blk_ready, key_valid, blk_load} !== 3'b000) begin n_bad++; $display("FAIL nokey i=%0d: rdy/kv/load=%b want 000", i, {blk_ready, key_valid, blk_load}); end
    end
    blk_valid = 1'b0;
  endtask

  task automatic test_key_load;
    do_reload(25);
  endtask

  task automatic test_encrypt;
    int w;
    run_block(1'b0, -1, 0, w);
    #1;
    n_cmp++; if ({blk_ready, out_valid, key_start} !== 3'b100) begin n_bad++; $display("FAIL enc_after: rdy/ov/ks=%b want 100", {blk_ready, out_valid, key_start}); end
  endtask

  task automatic test_decrypt;
    int w;
    run_block(1'b1, -1, 0, w);
    #1;
    n_cmp++; if (blk_ready !== 1'b1) begin n_bad++; $display("FAIL dec_after: blk_ready=%b want 1", blk_ready); end
  endtask

  task automatic test_back_to_back;
    int w;
    run_block(1'b0, -1, 0, w);
    run_block(1'b0, -1, 0, w);
    n_cmp++; if (w != 0) begin n_bad++; $display("FAIL b2b_gap: waited %0d want 0", w); end
  endtask

  task automatic test_key_req_run;
    int w;
    run_block(1'b0, 4, 5, w);
    #1;
    n_cmp++; if ({key_start, key_valid, blk_ready} !== 3'b100) begin n_bad++; $display("FAIL pend_reload: ks/kv/rdy=%b want 100", {key_start, key_valid, blk_ready}); end
    @(negedge clk); #1;
    n_cmp++; if (key_start !== 1'b0) begin n_bad++; $display("FAIL pend_single: key_start=%b want 0", key_start); end
    key_ready_s = 1'b1;
    @(negedge clk); key_ready_s = 1'b0; #1;
    n_cmp++; if ({key_valid, blk_ready} !== 2'b11) begin n_bad++; $display("FAIL pend_done: kv/rdy=%b want 11", {key_valid, blk_ready}); end
  endtask

  task automatic test_accept_and_req;
    int w;
    run_block(1'b0, 0, 0, w);
    #1;
    n_cmp++; if ({key_start, blk_ready} !== 2'b10) begin n_bad++; $display("FAIL same_cycle: ks/rdy=%b want 10", {key_start, blk_ready}); end
    repeat (3) @(negedge clk);
    key_ready_s = 1'b1;
    @(negedge clk); key_ready_s = 1'b0; #1;
    n_cmp++; if (key_valid !== 1'b1) begin n_bad++; $display("FAIL same_cycle_kv: key_valid=%b want 1", key_valid); end
  endtask

  task automatic test_reload_restart;
    key_req = 1'b1;
    @(negedge clk); key_req = 1'b0;
    @(negedge clk); key_req = 1'b1;
    @(negedge clk); key_req = 1'b0; #1;
    n_cmp++; if ({key_start, key_valid} !== 2'b10) begin n_bad++; $display("FAIL restart_pulse: ks/kv=%b want 10", {key_start, key_valid}); end
    key_ready_s = 1'b1;
    @(negedge clk); key_ready_s = 1'b0; #1;
    n_cmp++; if ({key_valid, blk_ready} !== 2'b11) begin n_bad++; $display("FAIL restart_done: kv/rdy=%b want 11", {key_valid, blk_ready}); end
  endtask

  task automatic test_reset_mid;
    blk_valid = 1'b1; blk_dec = 1'b0;
    @(negedge clk); blk_valid = 1'b0;
    for (int c = 2; c <= 5 + KL; c++) @(negedge clk);
    #1;
    n_cmp++; if (round_idx !== 4'd4) begin n_bad++; $display("FAIL mid_step: round_idx=%0d want 4", round_idx); end
    reset_n = 1'b0; #1;
    n_cmp++; if (outs_all !== 17'd0) begin n_bad++; $display("FAIL mid_reset_outs: got %h want 0", outs_all); end
    @(negedge clk); reset_n = 1'b1; blk_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      n_cmp++; if ({blk_ready, blk_load, out_valid} !== 3'b000) begin n_bad++; $display("FAIL post_reset i=%0d: rdy/load/ov=%b want 000", i, {blk_ready, blk_load, out_valid}); end
    end
    blk_valid = 1'b0;
    do_reload(4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_key_load();
    test_encrypt();
    test_decrypt();
    test_back_to_back();
    test_key_req_run();
    test_accept_and_req();
    test_reload_restart();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
